// File: rtl/can_rx_frame_sequencer.sv
// CAN 2.0A/B receive field sequencer: walks SOF..EOF on de-stuffed bits and extracts header/data.
// Optional CRC-15 check is compiled in when CAN_CRC_CHECK_EN is defined; otherwise crc_err is tied low.
`timescale 1ns/1ps
module can_rx_frame_sequencer #(
   parameter int MAX_DATA_BYTES = 8,
   parameter int BIT_CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sof,
   input  logic                 din,
   input  logic                 dvalid,
   input  logic                 error,
   input  logic                 overload,
   output logic                 sample_en,
   output logic [3:0]           field,
   output logic [BIT_CNT_W-1:0] bit_cnt,
   output logic [28:0]          id,
   output logic                 ide,
   output logic                 rtr,
   output logic [3:0]           dlc,
   output logic                 header_valid,
   output logic [7:0]           data_byte,
   output logic                 data_byte_valid,
   output logic                 frame_done,
   output logic                 form_err,
   output logic                 crc_err
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,  ID_A    = 4'd1,  SRR_RTR = 4'd2,  IDE     = 4'd3,
      ID_B    = 4'd4,  RTR_EXT = 4'd5,  RES     = 4'd6,  DLC     = 4'd7,
      DATA    = 4'd8,  CRC     = 4'd9,  CRC_DEL = 4'd10, ACK     = 4'd11,
      ACK_DEL = 4'd12, EOF     = 4'd13
   } state_t;

   state_t      state, next_state;
   logic [4:0]  cnt, next_cnt;
   logic [3:0]  bytes_left;
   logic [7:0]  data_sr;
   logic [3:0]  dlc_full;
   logic [3:0]  n_bytes;
   logic        abort, consume, last_bit, fixed_bad;
   logic        header_done, byte_done, eof_done, form_bad;

   assign field = state;

   always_comb begin
      abort       = (state != IDLE) && (error || overload);
      consume     = dvalid && !abort && ((state != IDLE) || sof);
      last_bit    = (cnt == 5'd0);
      dlc_full    = {dlc[2:0], din};
      fixed_bad   = !din && ((state == CRC_DEL) || (state == ACK_DEL) || (state == EOF));
      if (rtr)
         n_bytes = 4'd0;
      else if (int'(dlc_full) > MAX_DATA_BYTES)
         n_bytes = 4'(MAX_DATA_BYTES);
      else
         n_bytes = dlc_full;
      header_done = consume && (state == DLC) && last_bit;
      byte_done   = consume && (state == DATA) && last_bit;
      eof_done    = consume && !fixed_bad && (state == EOF) && last_bit;
      form_bad    = consume && fixed_bad;
      next_state  = state;
      next_cnt    = cnt;
      if (abort) begin
         next_state = IDLE;
         next_cnt   = 5'd0;
      end else if (consume) begin
         if (fixed_bad) begin
            next_state = IDLE;
            next_cnt   = 5'd0;
         end else if (!last_bit) begin
            next_cnt = cnt - 5'd1;
         end else begin
            case (state)
               IDLE:    next_state = ID_A;
               ID_A:    next_state = SRR_RTR;
               SRR_RTR: next_state = IDE;
               IDE:     next_state = din ? ID_B : RES;
               ID_B:    next_state = RTR_EXT;
               RTR_EXT: next_state = RES;
               RES:     next_state = DLC;
               DLC:     next_state = (n_bytes == 4'd0) ? CRC : DATA;
               DATA:    next_state = (bytes_left == 4'd1) ? CRC : DATA;
               CRC:     next_state = CRC_DEL;
               CRC_DEL: next_state = ACK;
               ACK:     next_state = ACK_DEL;
               ACK_DEL: next_state = EOF;
               EOF:     next_state = IDLE;
               default: next_state = IDLE;
            endcase
            // Counter holds (field length - 1); the extended reserved field is r1+r0.
            case (next_state)
               ID_A:    next_cnt = 5'd10;
               ID_B:    next_cnt = 5'd17;
               RES:     next_cnt = (state == RTR_EXT) ? 5'd1 : 5'd0;
               DLC:     next_cnt = 5'd3;
               DATA:    next_cnt = 5'd7;
               CRC:     next_cnt = 5'd14;
               EOF:     next_cnt = 5'd6;
               default: next_cnt = 5'd0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt             <= 5'd0;
         sample_en       <= 1'b0;
         bit_cnt         <= '0;
         id              <= '0;
         ide             <= 1'b0;
         rtr             <= 1'b0;
         dlc             <= 4'd0;
         bytes_left      <= 4'd0;
         data_sr         <= 8'd0;
         data_byte       <= 8'd0;
         header_valid    <= 1'b0;
         data_byte_valid <= 1'b0;
         frame_done      <= 1'b0;
         form_err        <= 1'b0;
      end else begin
         cnt             <= next_cnt;
         sample_en       <= (next_state != IDLE);
         header_valid    <= header_done;
         data_byte_valid <= byte_done;
         frame_done      <= eof_done;
         form_err        <= form_bad;
         if (consume) begin
            if (state == IDLE) begin
               bit_cnt <= BIT_CNT_W'(1);
               id      <= '0;
               ide     <= 1'b0;
               rtr     <= 1'b0;
               dlc     <= 4'd0;
            end else if (bit_cnt != '1) begin
               bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
            case (state)
               ID_A, ID_B:       id  <= {id[27:0], din};
               SRR_RTR, RTR_EXT: rtr <= din;
               IDE:              ide <= din;
               DLC: begin
                  dlc <= dlc_full;
                  if (last_bit)
                     bytes_left <= n_bytes;
               end
               DATA: begin
                  data_sr <= {data_sr[6:0], din};
                  if (last_bit) begin
                     data_byte  <= {data_sr[6:0], din};
                     bytes_left <= bytes_left - 4'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef CAN_CRC_CHECK_EN
   // Received CRC bits are fed through the same LFSR; a good frame leaves a zero remainder.
   logic [14:0] crc;

   function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
      logic [14:0] s;
      s = {c[13:0], 1'b0};
      if (b ^ c[14])
         s = s ^ 15'h4599;
      return s;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         crc     <= 15'd0;
         crc_err <= 1'b0;
      end else begin
         crc_err <= 1'b0;
         if (consume) begin
            if (state == IDLE)
               crc <= crc_step(15'd0, din);
            else if ((state >= ID_A) && (state <= CRC))
               crc <= crc_step(crc, din);
            if (state == CRC_DEL)
               crc_err <= (crc != 15'd0);
         end
      end
   end
`else
   assign crc_err = 1'b0;
`endif

endmodule
